// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the load/store unit.
// Accepts an active-low chip-select request, optionally inserts WAIT_CYCLES
// wait states, then performs a byte-lane-masked store or an extended load on
// a word-organised RAM and returns a one-cycle rvalid pulse.
// Optional feature macro: DMEM_MISALIGN_ERR_EN adds an err output that flags
// misaligned halfword/word accesses; such stores are dropped and such loads
// return zero.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    // Load codes carried on mask when rd=1
    localparam logic [3:0] LD_LB  = 4'b0000;
    localparam logic [3:0] LD_LH  = 4'b0001;
    localparam logic [3:0] LD_LW  = 4'b0010;
    localparam logic [3:0] LD_LBU = 4'b0011;
    localparam logic [3:0] LD_LHU = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Replicates store data so the selected lanes see the right bytes:
    // single byte lanes take wdata[7:0], the two aligned halves take
    // wdata[15:0], anything else is written lane-for-lane unshifted.
    function automatic logic [31:0] store_lanes(input logic [3:0] m, input logic [31:0] wd);
        logic [31:0] res;
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: res = {4{wd[7:0]}};
            4'b0011, 4'b1100:                   res = {2{wd[15:0]}};
            default:                            res = wd;
        endcase
        return res;
    endfunction

    // Selects and extends the byte/halfword/word addressed by the low
    // address bits; unknown load codes yield zero.
    function automatic logic [31:0] load_extract(input logic [3:0] m, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (m)
            LD_LB:   res = {{24{b[7]}}, b};
            LD_LH:   res = {{16{h[15]}}, h};
            LD_LW:   res = w;
            LD_LBU:  res = {24'd0, b};
            LD_LHU:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Flags halfword accesses on odd addresses and word accesses that are
    // not word aligned, for both loads and stores.
    function automatic logic misaligned(input logic r, input logic [3:0] m, input logic [1:0] a);
        logic res;
        if (r) begin
            res = (((m == LD_LH) || (m == LD_LHU)) && a[0]) ||
                  ((m == LD_LW) && (a != 2'b00));
        end else begin
            res = (((m == 4'b0011) || (m == 4'b1100)) && a[0]) ||
                  ((m == 4'b1111) && (a != 2'b00));
        end
        return res;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic [3:0]      mask_q, mask_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [0:DEPTH-1];
    logic [AW-1:0]   idx_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     wlane_s;
    logic            we_s;
    logic            mis_s;
    logic            unused_addr_s;

    // Upper address bits wrap onto the RAM and are deliberately dropped
    assign unused_addr_s = ^addr[31:AW+2];

    assign idx_s     = addr_q[AW+1:2];
    assign rd_word_s = mem_q[idx_s];
    assign wlane_s   = store_lanes(mask_q, wdata_q);

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_s = misaligned(rd_q, mask_q, addr_q[1:0]);
    assign err   = err_q;
`else
    assign mis_s = 1'b0;
`endif

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    // Hold the core for the whole request until the response cycle
    assign stall  = (cs == 1'b0) && (state_q != ST_RESP);

    // Next-state, request capture, response and write-enable decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        we_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs == 1'b0) begin
                    rd_d    = rd;
                    mask_d  = mask;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                state_d  = ST_RESP;
                rvalid_d = 1'b1;
                err_d    = mis_s;
                if (rd_q) begin
                    if (mis_s) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = load_extract(mask_q, addr_q[1:0], rd_word_s);
                    end
                end else begin
                    we_s = ~mis_s;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control/response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rd_q     <= 1'b0;
            mask_q   <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // RAM byte-lane write; contents survive reset, but a reset edge blocks the write
    always_ff @(posedge clk) begin
        if (rst_n && we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (0 and 3 wait states) share the
// request bus with separate chip selects. Directed steps cover the documented
// scenarios; random requests are checked against a word-level memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs0, cs3;
    logic        rd;
    logic [3:0]  mask;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata3;
    logic        rvalid0, rvalid3, stall0, stall3;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        err0, err3;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs0), .rd(rd), .mask(mask), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .stall(stall0)
`ifdef DMEM_MISALIGN_ERR_EN
        , .err(err0)
`endif
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cs(cs3), .rd(rd), .mask(mask), .addr(addr),
        .wdata(wdata), .rdata(rdata3), .rvalid(rvalid3), .stall(stall3)
`ifdef DMEM_MISALIGN_ERR_EN
        , .err(err3)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mm [2][1024];
    logic [31:0] last_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load: shift the word down, mask, extend arithmetically
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [3:0] m,
                                             input logic [31:0] a);
        int unsigned b, h, sb, sh;
        sb = 8 * int'(a[1:0]);
        sh = 16 * int'(a[1]);
        b  = (w >> sb) & 32'h0000_00FF;
        h  = (w >> sh) & 32'h0000_FFFF;
        case (m)
            4'd0:    return (b >= 128)   ? b - 32'd256   : b;
            4'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            4'd2:    return w;
            4'd3:    return b;
            4'd4:    return h;
            default: return 32'd0;
        endcase
    endfunction

    // Reference store: new word after a masked store of wd
    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [3:0] m,
                                              input logic [31:0] wd);
        int unsigned sh;
        logic [31:0] bm;
        case (m)
            4'b1111: return wd;
            4'b0011: return {w[31:16], wd[15:0]};
            4'b1100: return {wd[15:0], w[15:0]};
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                sh = (m == 4'b0001) ? 0 : (m == 4'b0010) ? 8 : (m == 4'b0100) ? 16 : 24;
                return (w & ~(32'h0000_00FF << sh)) | ({24'd0, wd[7:0]} << sh);
            end
            default: begin
                bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
                return (w & ~bm) | (wd & bm);
            end
        endcase
    endfunction

    // One request on instance sel, issued at a negedge; returns the rdata seen with rvalid
    task automatic txn(input int sel, input logic r, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input bit tog, input string tag,
                       output logic [31:0] got);
        int          w;
        int          idx;
        int          lat;
        logic [31:0] exp;
        logic        rv, st;
        w   = (sel == 1) ? 3 : 0;
        idx = int'(a[11:2]);
        lat = -1;
        got = 32'd0;
        exp = r ? ref_load(mm[sel][idx], m, a) : last_rd[sel];
        rd = r; mask = m; addr = a; wdata = wd;
        if (sel == 1) cs3 = 1'b0; else cs0 = 1'b0;
        #1;
        st = (sel == 1) ? stall3 : stall0;
        chk({tag, ".stall_c0"}, {31'd0, st}, 32'd1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            rv = (sel == 1) ? rvalid3 : rvalid0;
            st = (sel == 1) ? stall3 : stall0;
            if (rv) begin
                lat = c;
                got = (sel == 1) ? rdata3 : rdata0;
                chk({tag, ".stall_resp"}, {31'd0, st}, 32'd0);
                break;
            end
            chk({tag, ".stall_hold"}, {31'd0, st}, 32'd1);
            if (tog) begin
                rd = 1'($urandom); mask = 4'($urandom); addr = $urandom; wdata = $urandom;
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(w + 2));
        chk({tag, ".rdata"}, got, exp);
        if (sel == 1) cs3 = 1'b1; else cs0 = 1'b1;
        if (r) last_rd[sel] = exp;
        else mm[sel][idx] = ref_store(mm[sel][idx], m, wd);
        @(negedge clk);
        rv = (sel == 1) ? rvalid3 : rvalid0;
        chk({tag, ".pulse"}, {31'd0, rv}, 32'd0);
    endtask

    initial begin : main
        logic [31:0] got;
        logic [31:0] ra;
        int          seen;
        rst_n = 1'b0; cs0 = 1'b1; cs3 = 1'b1; rd = 1'b1; mask = 4'd0; addr = 32'd0; wdata = 32'd0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mm[0][i] = 32'd0; mm[1][i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst.rvalid3", {31'd0, rvalid3}, 32'd0);
        chk("rst.rdata0", rdata0, 32'd0);
        chk("rst.rdata3", rdata3, 32'd0);
        chk("rst.stall0", {31'd0, stall0}, 32'd0);

        // Full-word store then load, zero wait states
        txn(0, 1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, "st_w", got);
        txn(0, 1'b1, 4'd2, 32'h10, 32'd0, 1'b0, "ld_w", got);
        chk("lw_deadbeef", got, 32'hDEADBEEF);

        // Byte and halfword extraction
        txn(0, 1'b0, 4'b1111, 32'h10, 32'h80FF7F01, 1'b0, "st_ext", got);
        txn(0, 1'b1, 4'd0, 32'h13, 32'd0, 1'b0, "lb13", got);
        chk("lb_0x13", got, 32'hFFFFFF80);
        txn(0, 1'b1, 4'd3, 32'h13, 32'd0, 1'b0, "lbu13", got);
        chk("lbu_0x13", got, 32'h00000080);
        txn(0, 1'b1, 4'd0, 32'h10, 32'd0, 1'b0, "lb10", got);
        chk("lb_0x10", got, 32'h00000001);
        txn(0, 1'b1, 4'd1, 32'h12, 32'd0, 1'b0, "lh12", got);
        chk("lh_0x12", got, 32'hFFFF80FF);
        txn(0, 1'b1, 4'd4, 32'h12, 32'd0, 1'b0, "lhu12", got);
        chk("lhu_0x12", got, 32'h000080FF);
        txn(0, 1'b1, 4'd1, 32'h10, 32'd0, 1'b0, "lh10", got);
        chk("lh_0x10", got, 32'h00007F01);

        // Partial-lane stores
        txn(0, 1'b0, 4'b1111, 32'h10, 32'h11223344, 1'b0, "st_base", got);
        txn(0, 1'b0, 4'b0100, 32'h12, 32'h000000AA, 1'b0, "st_b2", got);
        txn(0, 1'b1, 4'd2, 32'h10, 32'd0, 1'b0, "ld_b2", got);
        chk("lane2_byte", got, 32'h11AA3344);
        txn(0, 1'b0, 4'b1100, 32'h12, 32'h0000BEEF, 1'b0, "st_h1", got);
        txn(0, 1'b1, 4'd2, 32'h10, 32'd0, 1'b0, "ld_h1", got);
        chk("upper_half", got, 32'hBEEF3344);

        // Three wait states, inputs scrambled while the request is in flight
        txn(1, 1'b0, 4'b1111, 32'h40, 32'hA5A55A5A, 1'b0, "w3_st", got);
        txn(1, 1'b1, 4'd2, 32'h40, 32'd0, 1'b1, "w3_ld_tog", got);
        chk("w3_lw", got, 32'hA5A55A5A);

        // Reset during WAIT of a store aborts it
        txn(1, 1'b0, 4'b1111, 32'h20, 32'h12345678, 1'b0, "rs_init", got);
        rd = 1'b0; mask = 4'b1111; addr = 32'h20; wdata = 32'hCAFEF00D; cs3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; cs3 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        chk("rs.rdata3", rdata3, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid3) seen++;
            @(negedge clk);
        end
        chk("rs.no_rvalid", 32'(seen), 32'd0);
        txn(1, 1'b1, 4'd2, 32'h20, 32'd0, 1'b0, "rs_ld", got);
        chk("rs.old_word", got, 32'h12345678);

        // Randomised traffic over a 16-word window with address wrap
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                txn(s, 1'b0, 4'b1111, 32'h100 + 32'(4 * k), $urandom, 1'b0, "rnd_init", got);
            end
            for (int n = 0; n < 40; n++) begin
                ra = ($urandom & 32'hFFFF_F000) | 32'h100 | ($urandom & 32'h3F);
                if ($urandom_range(0, 1) == 1) begin
                    txn(s, 1'b1, 4'($urandom_range(0, 6)), ra, $urandom, n[0], "rnd_ld", got);
                end else begin
                    txn(s, 1'b0, 4'($urandom_range(0, 15)), ra, $urandom, n[0], "rnd_st", got);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
